// File: rtl/mux41_rr.sv
// Four-channel valid/ready merger with round-robin arbitration and packet locking.
// One registered output beat tagged with its source channel in demux-select encoding.
module mux41_rr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    input  logic             v4,
    input  logic             last1,
    input  logic             last2,
    input  logic             last3,
    input  logic             last4,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic             r4,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       sel,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       o_dbg_state
);

    // Handshake: a beat moves on a channel or on the output only in a cycle
    // where its valid and ready are both high at the rising edge; a producer
    // holds data/last stable while valid is high and ready is low.

    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_sel;
    logic             r_out_last;
    logic             r_out_valid;
    logic [1:0]       r_ptr;
    logic             r_lock;
    logic [1:0]       r_lock_ch;

    logic [WIDTH-1:0] w_data [4];
    logic [3:0]       w_valid;
    logic [3:0]       w_last;
    logic             w_load;
    logic             w_gnt_any;
    logic [1:0]       w_gnt_idx;
    logic [1:0]       w_scan;
    logic [3:0]       w_ready;
    logic             w_xfer;

    assign w_data[0] = in1;
    assign w_data[1] = in2;
    assign w_data[2] = in3;
    assign w_data[3] = in4;
    assign w_valid   = {v4, v3, v2, v1};
    assign w_last    = {last4, last3, last2, last1};

    assign w_load = !r_out_valid || out_ready;

    // While locked only the packet owner may be granted, even if it has gone idle.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 2'd0;
        w_scan    = 2'd0;
        if (r_lock) begin
            w_gnt_any = w_valid[r_lock_ch];
            w_gnt_idx = r_lock_ch;
        end else begin
            for (int i = 0; i < 4; i++) begin
                w_scan = r_ptr + 2'(i);
                if (!w_gnt_any && w_valid[w_scan]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_scan;
                end
            end
        end
    end

    assign w_xfer  = w_load && w_gnt_any;
    // Readies are held low while in reset so no upstream beat is consumed then.
    assign w_ready = (rst_n && w_xfer) ? (4'b0001 << w_gnt_idx) : 4'b0000;

    assign r1 = w_ready[0];
    assign r2 = w_ready[1];
    assign r3 = w_ready[2];
    assign r4 = w_ready[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_sel       <= 2'd0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_ptr       <= 2'd0;
            r_lock      <= 1'b0;
            r_lock_ch   <= 2'd0;
        end else if (w_xfer) begin
            r_out       <= w_data[w_gnt_idx];
            r_sel       <= w_gnt_idx;
            r_out_last  <= w_last[w_gnt_idx];
            r_out_valid <= 1'b1;
            if (w_last[w_gnt_idx]) begin
                r_lock <= 1'b0;
                r_ptr  <= w_gnt_idx + 2'd1;
            end else begin
                r_lock    <= 1'b1;
                r_lock_ch <= w_gnt_idx;
            end
        end else if (w_load) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out         = r_out;
    assign sel         = r_sel;
    assign out_last    = r_out_last;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = {r_lock, r_lock_ch, r_ptr};

endmodule

// File: tb/tb_mux41_rr.sv
// Randomized and directed bench for mux41_rr against an arithmetic reference model.
module tb_mux41_rr;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] in1, in2, in3, in4;
  logic v1, v2, v3, v4, last1, last2, last3, last4;
  logic r1, r2, r3, r4;
  logic [W-1:0] out;
  logic [1:0] sel;
  logic out_last, out_valid, out_ready;
  logic [4:0] dbg;

  mux41_rr #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .v1(v1), .v2(v2), .v3(v3), .v4(v4),
    .last1(last1), .last2(last2), .last3(last3), .last4(last4),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .out(out), .sel(sel), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .o_dbg_state(dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int m_ptr, m_lock, m_lock_ch, m_sel;
  logic [W-1:0] m_out;
  bit m_last, m_valid;
  logic [3:0] last_r;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_lock_ch = 0; m_sel = 0;
    m_out = '0; m_last = 0; m_valid = 0;
  endtask

  function automatic int model_grant(input logic [3:0] v);
    if (m_lock != 0) return v[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // One clock: drive at negedge, compare everything mid-cycle, advance model after posedge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] lst,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3,
                       input logic ordy);
    logic [W-1:0] d [4];
    bit load;
    int g;
    logic [3:0] exp_r;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clk);
    {v4, v3, v2, v1} = v;
    {last4, last3, last2, last1} = lst;
    in1 = d0; in2 = d1; in3 = d2; in4 = d3;
    out_ready = ordy;
    #1;
    load = !m_valid || ordy;
    g = load ? model_grant(v) : -1;
    exp_r = (g >= 0) ? 4'(1 << g) : 4'b0000;
    last_r = {r4, r3, r2, r1};
    chk("ready", 32'(last_r), 32'(exp_r));
    chk("out", 32'(out), 32'(m_out));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("out_last", 32'(out_last), 32'(m_last));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("lock", 32'(dbg[4]), 32'(m_lock));
    chk("ptr", 32'(dbg[1:0]), 32'(m_ptr));
    if (m_valid && ordy) begin
      if (exp_q.size() == 0) chk("queue_underflow", 32'(1), 32'(0));
      else chk("drained_beat", 32'(out), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_out = d[g]; m_sel = g; m_last = lst[g]; m_valid = 1;
      exp_q.push_back(d[g]);
      if (lst[g]) begin m_lock = 0; m_ptr = (g + 1) % 4; end
      else begin m_lock = 1; m_lock_ch = g; end
    end else if (load) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {v4, v3, v2, v1} = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_sel", 32'(sel), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_ready", 32'({r4, r3, r2, r1}), 32'(0));
    chk("rst_lock", 32'(dbg[4]), 32'(0));
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    {v4, v3, v2, v1} = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input logic [W-1:0] eo, input logic [1:0] es, input logic ev);
    chk({name, "_out"}, 32'(out), 32'(eo));
    chk({name, "_sel"}, 32'(sel), 32'(es));
    chk({name, "_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    {v4, v3, v2, v1} = '0; {last4, last3, last2, last1} = '0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0; out_ready = 1'b1;
    model_reset();

    // reset, then round-robin fairness with single-beat packets
    do_reset();
    cycle(4'b1111, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    chk("first_grant_ready", 32'(last_r), 32'(4'b0001));
    lit("rr0", 4'd1, 2'd0, 1'b1);
    cycle(4'b1111, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1); lit("rr1", 4'd2, 2'd1, 1'b1);
    cycle(4'b1111, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1); lit("rr2", 4'd3, 2'd2, 1'b1);
    cycle(4'b1111, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1); lit("rr3", 4'd4, 2'd3, 1'b1);
    cycle(4'b1111, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1); lit("rr4", 4'd1, 2'd0, 1'b1);

    // packet lock on channel 2 with everyone else valid
    do_reset();
    cycle(4'b0001, 4'b1111, 4'h7, 4'h0, 4'h0, 4'h0, 1'b1); lit("pre", 4'h7, 2'd0, 1'b1);
    cycle(4'b1111, 4'b1101, 4'h1, 4'hA, 4'h3, 4'h4, 1'b1); lit("pktA", 4'hA, 2'd1, 1'b1);
    cycle(4'b1111, 4'b1101, 4'h1, 4'hB, 4'h3, 4'h4, 1'b1); lit("pktB", 4'hB, 2'd1, 1'b1);
    cycle(4'b1111, 4'b1111, 4'h1, 4'hC, 4'h3, 4'h4, 1'b1); lit("pktC", 4'hC, 2'd1, 1'b1);
    cycle(4'b1111, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1); lit("after_pkt", 4'h3, 2'd2, 1'b1);

    // back-pressure holds 0x9 for five cycles, then no bubble on release
    do_reset();
    cycle(4'b0001, 4'b1111, 4'h9, 4'h5, 4'h6, 4'h8, 1'b1); lit("bp_load", 4'h9, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b1111, 4'h9, 4'h5, 4'h6, 4'h8, 1'b0);
      chk("bp_ready_low", 32'(last_r), 32'(0));
      lit("bp_hold", 4'h9, 2'd0, 1'b1);
    end
    cycle(4'b1111, 4'b1111, 4'h9, 4'h5, 4'h6, 4'h8, 1'b1);
    chk("bp_release_ready", 32'(last_r), 32'(4'b0010));
    lit("bp_next", 4'h5, 2'd1, 1'b1);

    // locked channel 4 starves: channel 1 must wait
    do_reset();
    cycle(4'b1000, 4'b0000, 4'h1, 4'h0, 4'h0, 4'hE, 1'b1); lit("st_first", 4'hE, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001, 4'b1111, 4'h1, 4'h0, 4'h0, 4'hE, 1'b1);
      chk("st_r1_low", 32'(r1), 32'(0));
      chk("st_drained", 32'(out_valid), 32'(0));
    end
    cycle(4'b1001, 4'b1111, 4'h1, 4'h0, 4'h0, 4'hF, 1'b1); lit("st_tail", 4'hF, 2'd3, 1'b1);
    cycle(4'b1001, 4'b1111, 4'h1, 4'h0, 4'h0, 4'hF, 1'b1); lit("st_ch1", 4'h1, 2'd0, 1'b1);

    // reset in the middle of a channel-3 packet
    do_reset();
    cycle(4'b0100, 4'b0000, 4'h0, 4'h0, 4'hD, 4'h0, 1'b1); lit("mid_locked", 4'hD, 2'd2, 1'b1);
    chk("mid_lock_set", 32'(dbg[4]), 32'(1));
    do_reset();
    cycle(4'b1111, 4'b1111, 4'h2, 4'h3, 4'h4, 4'h5, 1'b1); lit("mid_after", 4'h2, 2'd0, 1'b1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mux41_rr.md
Name: mux41_rr

Overview:
- Four-to-one stream merger, the gather side of the 1-to-4 demux path.
- Four valid/ready input channels share one registered output.
- Arbitration is round-robin with packet locking. The output carries a 2-bit source tag, sel, that uses the same encoding as the demux select (0 = channel 1 … 3 = channel 4), so a downstream demux41 can route the data straight back.

Parameters:
WIDTH, 4, data width of each channel and of out

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in1, in2, in3, in4  input  WIDTH each  channel data
v1, v2, v3, v4  input  1 each  channel valid
last1, last2, last3, last4  input  1 each  final beat of packet on that channel
r1, r2, r3, r4  output  1 each  channel ready (combinational)
out  output  WIDTH  merged data (registered)
sel  output  2  source channel of current out beat (registered)
out_last  output  1  final-beat flag of current out beat (registered)
out_valid  output  1  out/sel/out_last hold a beat (registered)
out_ready  input  1  downstream accepts the beat

Behaviour:
- Reset values (async on rst_n low):
  - out = 0, sel = 0, out_last = 0, out_valid = 0.
  - Priority pointer ptr = 0 (channel 1 first).
  - lock = 0, lock_ch = 0.
- load = !out_valid || out_ready. The single output register may be written this cycle.
- Grant selection (combinational):
  - If lock = 1: candidate is lock_ch only, and only if its valid is high.
  - If lock = 0: first valid channel scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- rK = load && (granted channel == K). At most one rK is high at a time. rK may depend on vK.
- Transfer on a channel: vK && rK.
- On an input transfer, at the clock edge:
  - out <= inK, sel <= K-1, out_last <= lastK, out_valid <= 1.
  - If lastK = 1: lock <= 0, ptr <= (K-1)+1 mod 4.
  - If lastK = 0: lock <= 1, lock_ch <= K-1, ptr unchanged.
- load && no grant: out_valid <= 0. out, sel, out_last hold their last values.
- !load (out_valid && !out_ready): all registers hold and all rK = 0 (back-pressure).
- Throughput and latency:
  - One beat per clock when out_ready is held high.
  - Latency from input transfer to out_valid is 1 cycle.
  - Zero bubbles between back-to-back packets.
- Locked channel drops valid mid-packet:
  - No other channel is granted. Lock persists and out_valid falls to 0 once the held beat drains.
- Simultaneous events:
  - Output drain and new load in the same cycle are allowed (load covers out_ready).
  - All four valid with lock = 0: the ptr channel wins.
- Single-beat packets (last = 1 on every beat) give pure per-beat round-robin.
- Reset mid-packet: lock is cleared and any held beat is discarded. There is no partial-packet recovery.
- Width: data passes through unmodified. sel is exactly 2 bits and ptr wraps 3 -> 0.

Test Plan:
- Reset then idle:
  - rst_n low with all vK = 1 -> out = 0, sel = 0, out_valid = 0, rK all 0 during reset.
  - After release, first grant goes to channel 1.
- Round-robin fairness:
  - WIDTH = 4, in1..in4 = 1, 2, 3, 4, all vK = 1 and lastK = 1, out_ready = 1.
  - Expect out sequence 1, 2, 3, 4, 1, 2 … and sel 0, 1, 2, 3, 0 … one beat per cycle.
- Packet lock:
  - Channel 2 sends 3 beats (A, B, C with last on C) while channels 1, 3 and 4 are valid.
  - Expect out A, B, C with sel = 1 contiguous.
  - Next grant goes to channel 3 (ptr = 2).
- Back-pressure:
  - Hold out_ready = 0 for 5 cycles with out_valid = 1 and value 0x9.
  - Expect out = 0x9 stable and all rK = 0.
  - On release, the held beat is accepted and the next beat is loaded the same cycle with no bubble.
- Lock with starved channel:
  - Channel 4 sends a non-last beat, then v4 = 0 for 3 cycles while v1 = 1.
  - Expect r1 = 0 throughout and out_valid = 0 after the drain.
  - When v4 returns with last = 1, that beat is sent, then channel 1.
- Reset mid-packet:
  - Assert rst_n low while locked on channel 3 with out_valid = 1.
  - Expect immediate out_valid = 0 and lock cleared.
  - After release, channel 1 is granted first.
